// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with registered reads, optional
// write-to-read bypass, optional hardwired zero entry and a sequential bulk clear.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_adr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   rd_data_q [NUM_RD];
  logic [DATA_W-1:0]   rd_data_d [NUM_RD];
  logic [NUM_RD-1:0]   rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_adr_a [NUM_RD];
  logic                wr_ok;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    assign rd_adr_a[k]                  = rd_adr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W]  = rd_data_q[k];
  end

  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);

  // Writes to the hardwired zero entry are dropped here, so they never bypass either.
  assign wr_ok = wr_en && !(ZERO_REG && (wr_adr == '0));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (wr_ok) mem_d[wr_adr] = wr_data;
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_d[k]  = rd_data_q[k];
      rd_valid_d[k] = 1'b0;
      if (state_q == IDLE && rd_en[k]) begin
        rd_valid_d[k] = 1'b1;
        if (ZERO_REG && (rd_adr_a[k] == '0))
          rd_data_d[k] = '0;
        else if (BYPASS && wr_ok && (wr_adr == rd_adr_a[k]))
          rd_data_d[k] = wr_data;
        else
          rd_data_d[k] = mem_q[rd_adr_a[k]];
      end
    end
  end

  // NOTE: all state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_valid_q <= '0;
      // NOTE: the array is a reset flop bank, not a RAM macro, because every entry must read 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int k = 0; k < NUM_RD; k++) rd_data_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three builds (bypass, no bypass, zero register)
// driven by directed vectors; a negedge monitor compares every valid read.
module tb_regfile_mp;

  typedef struct {
    int          inst;
    int          port;
    logic [15:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic [2:0]        rst_v;
  logic [2:0][1:0]   rd_en_v;
  logic [2:0][9:0]   rd_adr_v;
  logic [2:0][31:0]  rd_data_v;
  logic [2:0][1:0]   rd_valid_v;
  logic [2:0]        wr_en_v;
  logic [2:0][4:0]   wr_adr_v;
  logic [2:0][15:0]  wr_data_v;
  logic [2:0]        clear_v;
  logic [2:0]        busy_v;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
    .clk(clk), .rst(rst_v[0]), .rd_en(rd_en_v[0]), .rd_adr(rd_adr_v[0]),
    .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]), .wr_en(wr_en_v[0]),
    .wr_adr(wr_adr_v[0]), .wr_data(wr_data_v[0]), .clear(clear_v[0]), .busy(busy_v[0])
  );

  regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
    .clk(clk), .rst(rst_v[1]), .rd_en(rd_en_v[1]), .rd_adr(rd_adr_v[1]),
    .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]), .wr_en(wr_en_v[1]),
    .wr_adr(wr_adr_v[1]), .wr_data(wr_data_v[1]), .clear(clear_v[1]), .busy(busy_v[1])
  );

  regfile_mp #(.BYPASS(1'b1), .ZERO_REG(1'b1)) u_zero (
    .clk(clk), .rst(rst_v[2]), .rd_en(rd_en_v[2]), .rd_adr(rd_adr_v[2]),
    .rd_data(rd_data_v[2]), .rd_valid(rd_valid_v[2]), .wr_en(wr_en_v[2]),
    .wr_adr(wr_adr_v[2]), .wr_data(wr_data_v[2]), .clear(clear_v[2]), .busy(busy_v[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i);
    rd_en_v[i] = '0;
    wr_en_v[i] = 1'b0;
    clear_v[i] = 1'b0;
  endtask

  // Issue port0 reads before port1 reads in a cycle; the monitor pops in that order.
  task automatic rd(input int i, input int p, input logic [4:0] adr, input logic [15:0] exp);
    rd_en_v[i][p]         = 1'b1;
    rd_adr_v[i][p*5 +: 5] = adr;
    sb.push_back('{inst: i, port: p, data: exp});
  endtask

  task automatic wr(input int i, input logic [4:0] adr, input logic [15:0] data);
    wr_en_v[i]   = 1'b1;
    wr_adr_v[i]  = adr;
    wr_data_v[i] = data;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (rd_valid_v[i][p] === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_rd_valid", 32'(rd_valid_v[i]), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rd_data_inst_port", {8'(i), 8'(p), rd_data_v[i][p*16 +: 16]},
                  {8'(e.inst), 8'(e.port), e.data});
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_v     = '1;
    rd_en_v   = '0;
    rd_adr_v  = '0;
    wr_en_v   = '0;
    wr_adr_v  = '0;
    wr_data_v = '0;
    clear_v   = '0;
    tick();
    tick();
    rst_v = '0;
    for (int i = 0; i < 3; i++) begin
      check("reset_rd_data", rd_data_v[i], 32'h0);
      check("reset_rd_valid", 32'(rd_valid_v[i]), 32'h0);
      check("reset_busy", 32'(busy_v[i]), 32'h0);
    end

    // Read after reset: port0 addr 0, port1 addr 31.
    rd(0, 0, 5'd0, 16'h0000); rd(0, 1, 5'd31, 16'h0000); tick(); idle(0);

    // Write then read, then hold for 3 idle cycles.
    wr(0, 5'd7, 16'hBEEF); tick(); idle(0);
    wr(0, 5'd8, 16'h1234); tick(); idle(0);
    rd(0, 0, 5'd7, 16'hBEEF); rd(0, 1, 5'd8, 16'h1234); tick(); idle(0);
    repeat (3) begin
      tick();
      check("hold_rd_valid", 32'(rd_valid_v[0]), 32'h0);
      check("hold_rd_data", rd_data_v[0], {16'h1234, 16'hBEEF});
    end

    // Same-cycle write/read of addr 3 with and without bypass.
    for (int i = 0; i < 2; i++) begin
      wr(i, 5'd3, 16'h0011); tick(); idle(i);
      wr(i, 5'd3, 16'hA5A5);
      rd(i, 0, 5'd3, (i == 0) ? 16'hA5A5 : 16'h0011);
      tick(); idle(i);
      rd(i, 0, 5'd3, 16'hA5A5); tick(); idle(i);
    end

    // Zero register build.
    wr(2, 5'd0, 16'hFFFF); tick(); idle(2);
    rd(2, 0, 5'd0, 16'h0000); tick(); idle(2);
    wr(2, 5'd0, 16'hFFFF); rd(2, 0, 5'd0, 16'h0000); rd(2, 1, 5'd0, 16'h0000); tick(); idle(2);
    wr(2, 5'd1, 16'h7777); tick(); idle(2);
    wr(2, 5'd1, 16'h1111); rd(2, 0, 5'd1, 16'h1111); tick(); idle(2);
    rd(2, 1, 5'd1, 16'h1111); tick(); idle(2);

    // Bulk clear: fill with index+1, spot-check, then clear with a same-cycle write and read.
    for (int a = 0; a < 32; a++) begin
      wr(0, 5'(a), 16'(a + 1)); tick(); idle(0);
    end
    rd(0, 0, 5'd0, 16'h0001); rd(0, 1, 5'd31, 16'h0020); tick(); idle(0);
    clear_v[0] = 1'b1; wr(0, 5'd31, 16'h9999); rd(0, 0, 5'd4, 16'h0005); tick(); idle(0);
    n = 0;
    while (busy_v[0] === 1'b1 && n < 64) begin
      n++;
      if (n == 10) begin
        wr(0, 5'd5, 16'h5555);
        clear_v[0]  = 1'b1;
        rd_en_v[0]  = 2'b11;
        rd_adr_v[0] = {5'd6, 5'd7};
      end
      tick(); idle(0);
    end
    check("clear_busy_cycles", 32'(n), 32'd32);
    check("clear_rd_hold", rd_data_v[0], {16'h0020, 16'h0005});
    for (int a = 0; a < 32; a += 2) begin
      rd(0, 0, 5'(a), 16'h0000); rd(0, 1, 5'(a + 1), 16'h0000); tick(); idle(0);
    end

    // Reset ten cycles into a clear.
    wr(0, 5'd20, 16'h2020); tick(); idle(0);
    wr(0, 5'd30, 16'h3030); tick(); idle(0);
    rd(0, 0, 5'd20, 16'h2020); rd(0, 1, 5'd30, 16'h3030); tick(); idle(0);
    clear_v[0] = 1'b1; tick(); idle(0);
    repeat (10) tick();
    check("busy_before_rst", 32'(busy_v[0]), 32'd1);
    rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
    check("rst_mid_clear_busy", 32'(busy_v[0]), 32'd0);
    check("rst_mid_clear_rd_valid", 32'(rd_valid_v[0]), 32'd0);
    check("rst_mid_clear_rd_data", rd_data_v[0], 32'h0);
    tick();
    check("rst_mid_clear_busy_stays_low", 32'(busy_v[0]), 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      rd(0, 0, 5'(a), 16'h0000); rd(0, 1, 5'(a + 1), 16'h0000); tick(); idle(0);
    end
    wr(0, 5'd20, 16'h0042); tick(); idle(0);
    rd(0, 0, 5'd20, 16'h0042); tick(); idle(0);

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
